// File: rtl/enoc_network_interface_pkg.sv
`default_nettype none
// ============================================================================
// enoc_network_interface_pkg
// Shared packet format and timestamp configuration for the ENoC network interface.
// Revision: 1.0
// ============================================================================
package enoc_network_interface_pkg;

    localparam int TS_WIDTH      = 16;
    localparam int COORD_WIDTH   = 4;
    localparam int PAYLOAD_WIDTH = 32;

    typedef struct packed {
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [COORD_WIDTH-1:0]   x_dest;
        logic [COORD_WIDTH-1:0]   y_dest;
        logic [COORD_WIDTH-1:0]   x_source;
        logic [COORD_WIDTH-1:0]   y_source;
        logic [TS_WIDTH-1:0]      timestamp;
    } packet_t;

    // Modular age of a packet; a wrap of the timestamp counter is absorbed by the subtraction
    function automatic logic [TS_WIDTH-1:0] ts_age(input logic [TS_WIDTH-1:0] now,
                                                   input logic [TS_WIDTH-1:0] stamp);
        return now - stamp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enoc_ni_inject_fifo.sv
`default_nettype none
// ============================================================================
// enoc_ni_inject_fifo
// Synchronous packet FIFO with push/pop, full/empty flags and asynchronous reset.
// Revision: 1.0
// ============================================================================
module enoc_ni_inject_fifo
    import enoc_network_interface_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  packet_t i_wr_data,
    input  logic    i_pop,
    output packet_t o_rd_data,
    output logic    o_full,
    output logic    o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    packet_t         r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == (c_AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    // A push into a full FIFO is refused even when a pop frees a slot in the same cycle
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= r_count + {{c_AW{1'b0}}, w_do_push} - {{c_AW{1'b0}}, w_do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule
`default_nettype wire

// File: rtl/enoc_network_interface.sv
`default_nettype none
// ============================================================================
// enoc_network_interface
// Core-side NI for an ENoC router: stamped injection, checked ejection, statistics.
// Revision: 1.0
// ============================================================================
module enoc_network_interface
    import enoc_network_interface_pkg::*;
#(
    parameter int X_NODES    = 4,
    parameter int Y_NODES    = 4,
    parameter int X_LOC      = 0,
    parameter int Y_LOC      = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  packet_t              i_core_data,
    input  logic                 i_core_val,
    output logic                 o_core_en,
    output packet_t              o_net_data,
    output logic                 o_net_val,
    input  logic                 i_net_en,
    input  packet_t              i_net_data,
    input  logic                 i_net_val,
    output logic                 o_net_en,
    output packet_t              o_core_rx_data,
    output logic                 o_core_rx_val,
    output logic [CNT_WIDTH-1:0] o_tx_count,
    output logic [CNT_WIDTH-1:0] o_rx_count,
    output logic [CNT_WIDTH-1:0] o_misroute_count,
    output logic [CNT_WIDTH-1:0] o_latency_sum
);

    localparam logic [COORD_WIDTH-1:0] c_X_LOC   = COORD_WIDTH'(X_LOC % X_NODES);
    localparam logic [COORD_WIDTH-1:0] c_Y_LOC   = COORD_WIDTH'(Y_LOC % Y_NODES);
    localparam logic [CNT_WIDTH-1:0]   c_CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam int c_SUM_W = ((CNT_WIDTH > TS_WIDTH) ? CNT_WIDTH : TS_WIDTH) + 1;

    logic [TS_WIDTH-1:0]  r_now;
    logic                 r_ready;
    packet_t              r_rx_data;
    logic                 r_rx_val;
    logic [CNT_WIDTH-1:0] r_tx_count;
    logic [CNT_WIDTH-1:0] r_rx_count;
    logic [CNT_WIDTH-1:0] r_mis_count;
    logic [CNT_WIDTH-1:0] r_lat_sum;

    packet_t              w_stamped;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_core_xfer;
    logic                 w_net_xfer;
    logic                 w_eject;
    logic                 w_match;
    logic [TS_WIDTH-1:0]  w_latency;
    logic [c_SUM_W-1:0]   w_lat_next;

    // ------------------------------------------------------------------------
    // Injection path
    // ------------------------------------------------------------------------
    assign o_core_en   = r_ready & ~w_full;
    assign o_net_val   = ~w_empty;
    assign w_core_xfer = i_core_val & o_core_en;
    assign w_net_xfer  = o_net_val & i_net_en;

    always_comb begin
        w_stamped           = i_core_data;
        w_stamped.x_source  = c_X_LOC;
        w_stamped.y_source  = c_Y_LOC;
        w_stamped.timestamp = r_now;
    end

    enoc_ni_inject_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_inject_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_push    (w_core_xfer),
        .i_wr_data (w_stamped),
        .i_pop     (w_net_xfer),
        .o_rd_data (o_net_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // ------------------------------------------------------------------------
    // Ejection path
    // ------------------------------------------------------------------------
    assign o_net_en   = r_ready;
    assign w_eject    = i_net_val & r_ready;
    assign w_match    = (i_net_data.x_dest == c_X_LOC) && (i_net_data.y_dest == c_Y_LOC);
    assign w_latency  = ts_age(r_now, i_net_data.timestamp);
    assign w_lat_next = c_SUM_W'(r_lat_sum) + c_SUM_W'(w_latency);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_now     <= '0;
            r_ready   <= 1'b0;
            r_rx_data <= '0;
            r_rx_val  <= 1'b0;
        end else begin
            r_now    <= r_now + TS_WIDTH'(1);
            r_ready  <= 1'b1;
            r_rx_val <= w_eject & w_match;
            if (w_eject && w_match) begin
                r_rx_data <= i_net_data;
            end
        end
    end

    assign o_core_rx_data = r_rx_data;
    assign o_core_rx_val  = r_rx_val;

    // ------------------------------------------------------------------------
    // Saturating statistics
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_count  <= '0;
            r_rx_count  <= '0;
            r_mis_count <= '0;
            r_lat_sum   <= '0;
        end else begin
            if (w_net_xfer && (r_tx_count != c_CNT_MAX)) begin
                r_tx_count <= r_tx_count + CNT_WIDTH'(1);
            end
            if (w_eject && w_match) begin
                if (r_rx_count != c_CNT_MAX) begin
                    r_rx_count <= r_rx_count + CNT_WIDTH'(1);
                end
                if (w_lat_next > c_SUM_W'(c_CNT_MAX)) begin
                    r_lat_sum <= c_CNT_MAX;
                end else begin
                    r_lat_sum <= w_lat_next[CNT_WIDTH-1:0];
                end
            end
            if (w_eject && !w_match && (r_mis_count != c_CNT_MAX)) begin
                r_mis_count <= r_mis_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o_tx_count       = r_tx_count;
    assign o_rx_count       = r_rx_count;
    assign o_misroute_count = r_mis_count;
    assign o_latency_sum    = r_lat_sum;

endmodule
`default_nettype wire

// File: tb/tb_enoc_network_interface.sv
`default_nettype none
// ============================================================================
// tb_enoc_network_interface
// Randomized bench with a queue-based reference model; a second DUT has 4-bit counters.
// Revision: 1.0
// ============================================================================
module tb_enoc_network_interface;
    import enoc_network_interface_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [3:0] MY_X = 4'd1;
    localparam logic [3:0] MY_Y = 4'd3;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    packet_t core_data;
    logic    core_val;
    logic    net_en_in;
    packet_t net_in_data;
    logic    net_in_val;

    logic        o_core_en, o_net_val, o_net_en, o_core_rx_val;
    packet_t     o_net_data, o_core_rx_data;
    logic [31:0] o_tx_count, o_rx_count, o_misroute_count, o_latency_sum;

    logic        s_core_en, s_net_val, s_net_en, s_core_rx_val;
    packet_t     s_net_data, s_core_rx_data;
    logic [3:0]  s_tx_count, s_rx_count, s_misroute_count, s_latency_sum;

    always #5 clk = ~clk;

    enoc_network_interface #(
        .X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(3), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(32)
    ) u_dut (
        .clk(clk), .reset(reset),
        .i_core_data(core_data), .i_core_val(core_val), .o_core_en(o_core_en),
        .o_net_data(o_net_data), .o_net_val(o_net_val), .i_net_en(net_en_in),
        .i_net_data(net_in_data), .i_net_val(net_in_val), .o_net_en(o_net_en),
        .o_core_rx_data(o_core_rx_data), .o_core_rx_val(o_core_rx_val),
        .o_tx_count(o_tx_count), .o_rx_count(o_rx_count),
        .o_misroute_count(o_misroute_count), .o_latency_sum(o_latency_sum)
    );

    enoc_network_interface #(
        .X_NODES(4), .Y_NODES(4), .X_LOC(1), .Y_LOC(3), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)
    ) u_sat (
        .clk(clk), .reset(reset),
        .i_core_data(core_data), .i_core_val(core_val), .o_core_en(s_core_en),
        .o_net_data(s_net_data), .o_net_val(s_net_val), .i_net_en(net_en_in),
        .i_net_data(net_in_data), .i_net_val(net_in_val), .o_net_en(s_net_en),
        .o_core_rx_data(s_core_rx_data), .o_core_rx_val(s_core_rx_val),
        .o_tx_count(s_tx_count), .o_rx_count(s_rx_count),
        .o_misroute_count(s_misroute_count), .o_latency_sum(s_latency_sum)
    );

    // Reference model state
    packet_t     m_q[$];
    logic [15:0] m_now;
    bit          m_ready;
    bit          m_rx_val;
    packet_t     m_rx_data;
    longint      m_tx, m_rx, m_mis, m_lat;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic packet_t rand_pkt();
        packet_t p;
        p.payload   = $urandom;
        p.x_dest    = 4'($urandom_range(0, 3));
        p.y_dest    = 4'($urandom_range(0, 3));
        p.x_source  = 4'($urandom);
        p.y_source  = 4'($urandom);
        p.timestamp = 16'($urandom);
        return p;
    endfunction

    task automatic check_outputs();
        check("core_en", 64'(o_core_en), 64'(m_ready && (m_q.size() < DEPTH)));
        check("net_val", 64'(o_net_val), 64'(m_q.size() > 0));
        if (m_q.size() > 0) check("net_data", o_net_data, m_q[0]);
        check("net_en", 64'(o_net_en), 64'(m_ready));
        check("rx_val", 64'(o_core_rx_val), 64'(m_rx_val));
        if (m_rx_val) check("rx_data", o_core_rx_data, m_rx_data);
        check("tx_count", 64'(o_tx_count), 64'(sat(m_tx, 32)));
        check("rx_count", 64'(o_rx_count), 64'(sat(m_rx, 32)));
        check("mis_count", 64'(o_misroute_count), 64'(sat(m_mis, 32)));
        check("lat_sum", 64'(o_latency_sum), 64'(sat(m_lat, 32)));
        check("sat_tx", 64'(s_tx_count), 64'(sat(m_tx, 4)));
        check("sat_rx", 64'(s_rx_count), 64'(sat(m_rx, 4)));
        check("sat_mis", 64'(s_misroute_count), 64'(sat(m_mis, 4)));
        check("sat_lat", 64'(s_latency_sum), 64'(sat(m_lat, 4)));
    endtask

    task automatic idle();
        core_val    = 1'b0;
        net_in_val  = 1'b0;
        net_en_in   = 1'b0;
        core_data   = '0;
        net_in_data = '0;
    endtask

    // One clock: decide transfers from the model's view, advance the model, then compare
    task automatic step();
        bit          cx, nx, ex;
        packet_t     st;
        logic [15:0] age;
        cx = core_val && m_ready && (m_q.size() < DEPTH);
        nx = (m_q.size() > 0) && net_en_in;
        ex = net_in_val && m_ready;
        @(posedge clk);
        if (nx) begin
            void'(m_q.pop_front());
            m_tx++;
        end
        if (cx) begin
            st           = core_data;
            st.x_source  = MY_X;
            st.y_source  = MY_Y;
            st.timestamp = m_now;
            m_q.push_back(st);
        end
        m_rx_val = 1'b0;
        if (ex) begin
            if (net_in_data.x_dest == MY_X && net_in_data.y_dest == MY_Y) begin
                m_rx_val  = 1'b1;
                m_rx_data = net_in_data;
                m_rx++;
                age   = m_now - net_in_data.timestamp;
                m_lat += longint'(age);
            end else begin
                m_mis++;
            end
        end
        m_now   = m_now + 16'd1;
        m_ready = 1'b1;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        m_q.delete();
        m_now    = '0;
        m_ready  = 1'b0;
        m_rx_val = 1'b0;
        m_tx = 0; m_rx = 0; m_mis = 0; m_lat = 0;
        check_outputs();
        check("rst_net_data", o_net_data, 64'd0);
        check("rst_rx_data", o_core_rx_data, 64'd0);
        @(negedge clk);
        idle();
        reset = 1'b0;
        step();
    endtask

    task automatic step_until(input logic [15:0] t);
        idle();
        for (int i = 0; i < 1000 && m_now != t; i++) step();
        check("reach_now", 64'(m_now), 64'(t));
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();

        // Single injection stamped at now=5
        step_until(16'd5);
        core_data        = rand_pkt();
        core_data.x_dest = 4'd2;
        core_data.y_dest = 4'd1;
        core_val         = 1'b1;
        net_en_in        = 1'b1;
        step();
        check("inj_ts", 64'(o_net_data.timestamp), 64'd5);
        check("inj_xsrc", 64'(o_net_data.x_source), 64'd1);
        check("inj_ysrc", 64'(o_net_data.y_source), 64'd3);
        core_val = 1'b0;
        step();
        check("inj_tx", 64'(o_tx_count), 64'd1);

        // Backpressure: 6 offered, 4 accepted, then drain in order
        net_en_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            core_data = rand_pkt();
            core_val  = 1'b1;
            step();
        end
        check("bp_full", 64'(o_core_en), 64'd0);
        core_val  = 1'b0;
        net_en_in = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("bp_tx", 64'(o_tx_count), 64'd5);

        // Eject with latency 30
        step_until(16'd130);
        net_in_data           = rand_pkt();
        net_in_data.x_dest    = MY_X;
        net_in_data.y_dest    = MY_Y;
        net_in_data.timestamp = 16'd100;
        net_in_val            = 1'b1;
        step();
        check("ej_val", 64'(o_core_rx_val), 64'd1);
        check("ej_lat", 64'(o_latency_sum), 64'd30);
        idle();
        step();

        // Misroute
        net_in_data        = rand_pkt();
        net_in_data.x_dest = 4'd2;
        net_in_data.y_dest = MY_Y;
        net_in_val         = 1'b1;
        step();
        check("mis_cnt", 64'(o_misroute_count), 64'd1);
        idle();

        // Reset with three packets buffered, then latency across a wrap
        for (int i = 0; i < 3; i++) begin
            core_data = rand_pkt();
            core_val  = 1'b1;
            step();
        end
        do_reset();
        step_until(16'd4);
        net_in_data           = rand_pkt();
        net_in_data.x_dest    = MY_X;
        net_in_data.y_dest    = MY_Y;
        net_in_data.timestamp = 16'd65530;
        net_in_val            = 1'b1;
        step();
        check("wrap_lat", 64'(o_latency_sum), 64'd10);
        idle();

        // 50 cycles of concurrent inject and eject
        do_reset();
        for (int i = 0; i < 50; i++) begin
            core_data          = rand_pkt();
            core_val           = 1'b1;
            net_en_in          = 1'b1;
            net_in_data        = rand_pkt();
            net_in_data.x_dest = MY_X;
            net_in_data.y_dest = MY_Y;
            net_in_val         = 1'b1;
            step();
        end
        idle();
        net_en_in = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("conc_tx", 64'(o_tx_count), 64'd50);
        check("conc_rx", 64'(o_rx_count), 64'd50);
        check("conc_sat_rx", 64'(s_rx_count), 64'd15);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            core_data  = rand_pkt();
            core_val   = ($urandom_range(0, 3) != 0);
            net_en_in  = ($urandom_range(0, 2) != 0);
            net_in_data = rand_pkt();
            if ($urandom_range(0, 3) != 0) begin
                net_in_data.x_dest = MY_X;
                net_in_data.y_dest = MY_Y;
            end
            net_in_val = $urandom_range(0, 1) != 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
